rom_access_arbiter: RTL and testbench
=====================================

Name: rom_access_arbiter

Overview:
Shares the single serial ROM/RAM memory controller between two requesters: the ROM stream loader (write port) and the CPU instruction fetch (read port). Grants one transaction at a time with round-robin fairness, latches address/data at grant, and sequences the controller's request/busy handshake. A watchdog aborts transactions the controller never accepts and raises a sticky error flag. The block sits between the loader/CPU and the memory controller.

Parameters:
DATA_WIDTH, 16, width of write and read data
ADDRESS_WIDTH, 16, width of memory address
TIMEOUT_CYCLES, 64, max cycles in ISSUE waiting for mem_busy to rise before abort (must be >= 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
ld_request  input  1  loader write request, held until ld_busy seen high
ld_address  input  ADDRESS_WIDTH  loader write address
ld_data  input  DATA_WIDTH  loader write data
ld_busy  output  1  high while the loader's own transaction is in flight
ld_initialized  output  1  equals mem_initialized (combinational)
cpu_request  input  1  CPU read request, held until cpu_data_valid
cpu_address  input  ADDRESS_WIDTH  CPU read address
cpu_busy  output  1  high while the CPU's transaction is in flight
cpu_data  output  DATA_WIDTH  read data, valid when cpu_data_valid
cpu_data_valid  output  1  one-cycle pulse on read completion
mem_request  output  1  request to memory controller
mem_write  output  1  1 = write, 0 = read; stable for whole transaction
mem_address  output  ADDRESS_WIDTH  latched transaction address
mem_wdata  output  DATA_WIDTH  latched write data
mem_rdata  input  DATA_WIDTH  controller read data, valid when mem_busy falls
mem_busy  input  1  controller busy
mem_initialized  input  1  controller ready for traffic
timeout_error  output  1  sticky; set on any watchdog abort

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = CPU, so the loader wins the first tie; watchdog = 0; cpu_data = 0.
- State machine, all outputs registered except ld_initialized:
  - IDLE: no grant while mem_initialized=0 or mem_busy=1. Otherwise, if exactly one request is pending, grant it. If both are pending, grant the port not equal to last_grant. On grant: latch address, data and mem_write; set owner busy; mem_request=1; last_grant=owner; watchdog=0; go to ISSUE. Grant occurs one cycle after the request is sampled.
  - ISSUE: if mem_busy=1, drop mem_request and go to WAIT. Otherwise increment the watchdog. When the watchdog reaches TIMEOUT_CYCLES-1, drop mem_request, clear owner busy, set timeout_error, and go to IDLE. No cpu_data_valid is generated on abort; the requester keeps requesting and is re-arbitrated.
  - WAIT: when mem_busy=0, the transaction is complete. Clear owner busy. For a read, capture mem_rdata into cpu_data and pulse cpu_data_valid. Go to IDLE. WAIT has no timeout.
- IDLE lasts at least one cycle between transactions, so back-to-back grants are never issued on consecutive cycles.
- ld_busy is never asserted while the CPU owns the controller. A loader request pending during a CPU transaction sees ld_busy=0 and simply waits; the same holds for the CPU.
- Requests that drop before grant are ignored; no state is kept.
- Input changes after grant do not affect the transaction, because address and data are latched at grant.
- If mem_initialized falls mid-transaction, the FSM continues on mem_busy alone; only new grants are blocked.
- Reset mid-transaction returns to IDLE immediately and clears mem_request, busy flags and timeout_error.
- Invariants:
  - at most one of ld_busy/cpu_busy is high;
  - mem_request implies exactly one owner busy;
  - cpu_data_valid is never high while cpu_busy is high.

Test Plan:
- Single loader write: ld_request=1, addr 0x0005, data 0xBEEF; controller raises busy 1 cycle after mem_request and holds it 4 cycles -> mem_request high 1 cycle after request, mem_write=1, mem_address=0x0005, mem_wdata=0xBEEF; ld_busy falls the cycle after mem_busy falls; no cpu_data_valid.
- Single CPU read: cpu_request, addr 0x0010, controller returns 0x1234 -> cpu_data=0x1234 with a one-cycle cpu_data_valid; cpu_busy falls on the same edge.
- Contention: both requesters held continuously for 4 transactions from reset -> grant order loader, CPU, loader, CPU; busy flags never overlap.
- Not initialized: mem_initialized=0 for 10 cycles with ld_request=1 -> no mem_request and ld_initialized=0; the grant occurs 1 cycle after mem_initialized rises.
- Timeout: controller never raises busy, TIMEOUT_CYCLES=8 -> mem_request drops after 8 cycles in ISSUE, timeout_error=1 sticky, requester re-granted after the IDLE cycle; reset clears timeout_error.
- Reset during WAIT of a CPU read -> next cycle all outputs 0, state IDLE, no cpu_data_valid.

Source files
------------

// File: rtl/rom_access_arbiter_if.sv
// Handshake bundle between the loader/CPU requesters, the arbiter and the serial memory controller.
interface rom_access_arbiter_if #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 16
);
    logic                     ld_request;
    logic [ADDRESS_WIDTH-1:0] ld_address;
    logic [DATA_WIDTH-1:0]    ld_data;
    logic                     ld_busy;
    logic                     ld_initialized;
    logic                     cpu_request;
    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic                     cpu_busy;
    logic [DATA_WIDTH-1:0]    cpu_data;
    logic                     cpu_data_valid;
    logic                     mem_request;
    logic                     mem_write;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     mem_busy;
    logic                     mem_initialized;
    logic                     timeout_error;

    // Arbiter side
    modport slave (
        input  ld_request, ld_address, ld_data, cpu_request, cpu_address,
               mem_rdata, mem_busy, mem_initialized,
        output ld_busy, ld_initialized, cpu_busy, cpu_data, cpu_data_valid,
               mem_request, mem_write, mem_address, mem_wdata, timeout_error
    );

    // Requester / controller side
    modport master (
        output ld_request, ld_address, ld_data, cpu_request, cpu_address,
               mem_rdata, mem_busy, mem_initialized,
        input  ld_busy, ld_initialized, cpu_busy, cpu_data, cpu_data_valid,
               mem_request, mem_write, mem_address, mem_wdata, timeout_error
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// Shares the serial memory controller between the ROM loader (writes) and CPU fetch (reads):
// round-robin grant, transaction latched at grant, request/busy sequencing with an ISSUE watchdog.
module rom_access_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic                 clk,
    input logic                 reset,
    rom_access_arbiter_if.slave bus
);
    localparam int unsigned WD_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic {OWN_LD, OWN_CPU} owner_t;

    state_t                   state_q, state_d;
    owner_t                   last_grant_q, last_grant_d;
    logic [WD_WIDTH-1:0]      wd_q, wd_d;
    logic                     mem_request_q, mem_request_d;
    logic                     mem_write_q, mem_write_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     ld_busy_q, ld_busy_d;
    logic                     cpu_busy_q, cpu_busy_d;
    logic [DATA_WIDTH-1:0]    cpu_data_q, cpu_data_d;
    logic                     cpu_data_valid_q, cpu_data_valid_d;
    logic                     timeout_error_q, timeout_error_d;
    logic                     grant_cpu;

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        wd_d             = wd_q;
        mem_request_d    = mem_request_q;
        mem_write_d      = mem_write_q;
        mem_address_d    = mem_address_q;
        mem_wdata_d      = mem_wdata_q;
        ld_busy_d        = ld_busy_q;
        cpu_busy_d       = cpu_busy_q;
        cpu_data_d       = cpu_data_q;
        cpu_data_valid_d = 1'b0;
        timeout_error_d  = timeout_error_q;
        grant_cpu        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_initialized && !bus.mem_busy && (bus.ld_request || bus.cpu_request)) begin
                    // On a tie the port that did not win last time gets the controller
                    grant_cpu     = bus.cpu_request && (!bus.ld_request || last_grant_q == OWN_LD);
                    last_grant_d  = grant_cpu ? OWN_CPU : OWN_LD;
                    mem_write_d   = !grant_cpu;
                    mem_address_d = grant_cpu ? bus.cpu_address : bus.ld_address;
                    if (!grant_cpu) begin
                        mem_wdata_d = bus.ld_data;
                    end
                    ld_busy_d     = !grant_cpu;
                    cpu_busy_d    = grant_cpu;
                    mem_request_d = 1'b1;
                    wd_d          = '0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_busy) begin
                    mem_request_d = 1'b0;
                    state_d       = ST_WAIT;
                end else if (wd_q == WD_LAST) begin
                    // Controller never accepted: abort, requester will be re-arbitrated
                    mem_request_d   = 1'b0;
                    ld_busy_d       = 1'b0;
                    cpu_busy_d      = 1'b0;
                    timeout_error_d = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_WIDTH'(1);
                end
            end
            ST_WAIT: begin
                if (!bus.mem_busy) begin
                    ld_busy_d  = 1'b0;
                    cpu_busy_d = 1'b0;
                    if (!mem_write_q) begin
                        cpu_data_d       = bus.mem_rdata;
                        cpu_data_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            last_grant_q     <= OWN_CPU;
            wd_q             <= '0;
            mem_request_q    <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_wdata_q      <= '0;
            ld_busy_q        <= 1'b0;
            cpu_busy_q       <= 1'b0;
            cpu_data_q       <= '0;
            cpu_data_valid_q <= 1'b0;
            timeout_error_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            wd_q             <= wd_d;
            mem_request_q    <= mem_request_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_wdata_q      <= mem_wdata_d;
            ld_busy_q        <= ld_busy_d;
            cpu_busy_q       <= cpu_busy_d;
            cpu_data_q       <= cpu_data_d;
            cpu_data_valid_q <= cpu_data_valid_d;
            timeout_error_q  <= timeout_error_d;
        end
    end

    assign bus.ld_initialized = bus.mem_initialized;
    assign bus.ld_busy        = ld_busy_q;
    assign bus.cpu_busy       = cpu_busy_q;
    assign bus.cpu_data       = cpu_data_q;
    assign bus.cpu_data_valid = cpu_data_valid_q;
    assign bus.mem_request    = mem_request_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.timeout_error  = timeout_error_q;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: controller model with a transaction scoreboard and read-data queue.
module tb_rom_access_arbiter;
    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_txn_t;

    logic clk;
    logic reset;
    int   checks      = 0;
    int   failures    = 0;
    int   grants_seen = 0;
    int   busy_len    = 4;
    logic ctrl_respond;
    logic [15:0] rd_value;
    mem_txn_t    mem_exp[$];
    logic [15:0] rd_exp[$];

    rom_access_arbiter_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) bus ();

    rom_access_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.ld_busy, bus.cpu_busy, bus.cpu_data, bus.cpu_data_valid, bus.mem_request,
                    bus.mem_write, bus.mem_address, bus.mem_wdata, bus.timeout_error});
    endfunction

    // Controller model: busy rises the cycle after request is first seen, stays high busy_len cycles
    initial begin : mem_ctrl
        int       cnt;
        logic     req_prev;
        logic     pending;
        logic     rst_s;
        mem_txn_t e;
        cnt = 0; req_prev = 1'b0; pending = 1'b0;
        bus.mem_busy = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            rst_s = reset;
            #1;
            if (rst_s) begin
                bus.mem_busy = 1'b0; cnt = 0; pending = 1'b0; req_prev = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.mem_busy  = 1'b0;
                        bus.mem_rdata = rd_value;
                    end
                end else if (pending && bus.mem_request) begin
                    bus.mem_busy  = 1'b1;
                    bus.mem_rdata = 16'hDEAD;
                    cnt = busy_len;
                    pending = 1'b0;
                end
                if (bus.mem_request && !req_prev) begin
                    grants_seen++;
                    check("grant_expected", 64'(mem_exp.size() != 0), 64'd1);
                    if (mem_exp.size() != 0) begin
                        e = mem_exp.pop_front();
                        check("mem_write", 64'(bus.mem_write), 64'(e.write));
                        check("mem_address", 64'(bus.mem_address), 64'(e.addr));
                        if (e.write) check("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
                    end
                    if (ctrl_respond) pending = 1'b1;
                end
                if (!bus.mem_request && cnt == 0 && !bus.mem_busy) pending = 1'b0;
                req_prev = bus.mem_request;
            end
        end
    end

    // Per-cycle invariants and read-data scoreboard
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            check("invariants", 64'({bus.ld_busy && bus.cpu_busy,
                                     bus.mem_request && !(bus.ld_busy ^ bus.cpu_busy),
                                     bus.cpu_data_valid && bus.cpu_busy}), 64'd0);
            if (bus.cpu_data_valid) begin
                check("cpu_data_valid_expected", 64'(rd_exp.size() != 0), 64'd1);
                if (rd_exp.size() != 0) check("cpu_data", 64'(bus.cpu_data), 64'(rd_exp.pop_front()));
            end
        end
    end

    initial begin : hang_guard
        #200000;
        $display("FAIL hang_guard simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int n;
        reset = 1'b1;
        ctrl_respond = 1'b1;
        rd_value = 16'h0000;
        bus.ld_request = 1'b0; bus.ld_address = '0; bus.ld_data = '0;
        bus.cpu_request = 1'b0; bus.cpu_address = '0;
        bus.mem_initialized = 1'b1;
        tick(2);
        check("reset_outputs", outs(), 64'd0);
        check("reset_ld_initialized", 64'(bus.ld_initialized), 64'd1);
        reset = 1'b0;

        // Single loader write; inputs scrambled after grant must not matter
        mem_exp.push_back('{write: 1'b1, addr: 16'h0005, wdata: 16'hBEEF});
        bus.ld_request = 1'b1; bus.ld_address = 16'h0005; bus.ld_data = 16'hBEEF;
        tick(1);
        check("wr_grant", 64'({bus.mem_request, bus.mem_write, bus.ld_busy, bus.cpu_busy}), 64'b1110);
        check("wr_address", 64'(bus.mem_address), 64'h0005);
        check("wr_wdata", 64'(bus.mem_wdata), 64'hBEEF);
        bus.ld_request = 1'b0; bus.ld_address = 16'hFFFF; bus.ld_data = 16'h0000;
        n = 0;
        while (bus.ld_busy && n < 50) begin tick(1); n++; end
        check("wr_ld_busy_latency", 64'(n), 64'd6);
        check("wr_latched_after", 64'({bus.mem_address, bus.mem_wdata}), 64'h0005_BEEF);
        tick(1);

        // Single CPU read
        mem_exp.push_back('{write: 1'b0, addr: 16'h0010, wdata: 16'h0000});
        rd_value = 16'h1234;
        rd_exp.push_back(16'h1234);
        bus.cpu_request = 1'b1; bus.cpu_address = 16'h0010;
        tick(1);
        check("rd_grant", 64'({bus.mem_request, bus.mem_write, bus.ld_busy, bus.cpu_busy}), 64'b1001);
        n = 0;
        while (!bus.cpu_data_valid && n < 50) begin tick(1); n++; end
        check("rd_valid_seen", 64'({bus.cpu_data_valid, bus.cpu_busy}), 64'b10);
        check("rd_data", 64'(bus.cpu_data), 64'h1234);
        bus.cpu_request = 1'b0;
        tick(1);
        check("rd_valid_pulse", 64'(bus.cpu_data_valid), 64'd0);
        tick(1);

        // Contention from reset: L, C, L, C
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rd_value = 16'h5A5A;
        for (int i = 0; i < 2; i++) begin
            mem_exp.push_back('{write: 1'b1, addr: 16'h0100, wdata: 16'hA001});
            mem_exp.push_back('{write: 1'b0, addr: 16'h0200, wdata: 16'h0000});
            rd_exp.push_back(16'h5A5A);
        end
        n = grants_seen;
        bus.ld_request = 1'b1; bus.ld_address = 16'h0100; bus.ld_data = 16'hA001;
        bus.cpu_request = 1'b1; bus.cpu_address = 16'h0200;
        for (int c = 0; c < 200 && grants_seen < n + 4; c++) tick(1);
        check("contention_grants", 64'(grants_seen - n), 64'd4);
        bus.ld_request = 1'b0; bus.cpu_request = 1'b0;
        n = 0;
        while ((bus.ld_busy || bus.cpu_busy || bus.mem_request) && n < 50) begin tick(1); n++; end
        tick(1);
        check("contention_drained", 64'({mem_exp.size() != 0, rd_exp.size() != 0}), 64'd0);

        // Not initialized: no grant until mem_initialized rises
        bus.mem_initialized = 1'b0;
        mem_exp.push_back('{write: 1'b1, addr: 16'h0033, wdata: 16'h7777});
        bus.ld_request = 1'b1; bus.ld_address = 16'h0033; bus.ld_data = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check("uninit_blocked", 64'({bus.mem_request, bus.ld_initialized}), 64'd0);
        end
        bus.mem_initialized = 1'b1;
        tick(1);
        check("uninit_grant", 64'({bus.mem_request, bus.ld_initialized, bus.ld_busy}), 64'b111);
        bus.ld_request = 1'b0;
        n = 0;
        while (bus.ld_busy && n < 50) begin tick(1); n++; end
        tick(1);

        // Watchdog abort, re-grant after one IDLE cycle, sticky error until reset
        ctrl_respond = 1'b0;
        rd_value = 16'hC0DE;
        mem_exp.push_back('{write: 1'b0, addr: 16'h0044, wdata: 16'h0000});
        mem_exp.push_back('{write: 1'b0, addr: 16'h0044, wdata: 16'h0000});
        rd_exp.push_back(16'hC0DE);
        bus.cpu_request = 1'b1; bus.cpu_address = 16'h0044;
        tick(1);
        n = 0;
        while (bus.mem_request && n < 50) begin tick(1); n++; end
        check("timeout_issue_cycles", 64'(n), 64'd8);
        check("timeout_abort", 64'({bus.timeout_error, bus.cpu_busy, bus.cpu_data_valid}), 64'b100);
        ctrl_respond = 1'b1;
        tick(1);
        check("timeout_regrant", 64'({bus.mem_request, bus.cpu_busy, bus.timeout_error}), 64'b111);
        n = 0;
        while (!bus.cpu_data_valid && n < 50) begin tick(1); n++; end
        check("timeout_retry_done", 64'({bus.cpu_data_valid, bus.timeout_error}), 64'b11);
        bus.cpu_request = 1'b0;
        tick(2);
        check("timeout_sticky", 64'(bus.timeout_error), 64'd1);
        reset = 1'b1;
        tick(1);
        check("timeout_reset_clears", outs(), 64'd0);
        reset = 1'b0;
        tick(1);

        // Reset during WAIT of a CPU read
        mem_exp.push_back('{write: 1'b0, addr: 16'h0055, wdata: 16'h0000});
        rd_value = 16'h9999;
        bus.cpu_request = 1'b1; bus.cpu_address = 16'h0055;
        n = 0;
        do begin tick(1); n++; end while (!(bus.cpu_busy && !bus.mem_request) && n < 50);
        check("wait_reached", 64'({bus.cpu_busy, bus.mem_request}), 64'b10);
        reset = 1'b1;
        bus.cpu_request = 1'b0;
        tick(1);
        check("reset_in_wait", outs(), 64'd0);
        reset = 1'b0;
        tick(6);
        check("after_reset_quiet", outs(), 64'd0);
        check("queues_empty", 64'({mem_exp.size() != 0, rd_exp.size() != 0}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
